// File: rtl/clk_div_ctrl.sv
`timescale 1ns/100ps
// clk_div_ctrl: runtime-programmable 50%-duty clock divider (odd and even ratios).
// New ratios arrive over a valid/ready port and take effect only at an output
// period boundary, where clk_out is guaranteed low, so ratio changes, starts
// and stops never produce a truncated or glitched pulse.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         running,
  output logic         clk_out
);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (1 << W) - 1) begin : g_bad_default
    $error("clk_div_ctrl: DEFAULT_DIV must lie in 2 .. 2**W-1");
  end

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE     = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]   div_nxt;
  logic [W-1:0]   pend_div, pend_nxt;
  logic           a, a_nxt;
  logic           b;
  logic           err_nxt;
  logic           accept;
  logic           ratio_ok;
  logic           boundary;

  // High-phase length in source cycles: N/2 for even N, (N+1)/2 for odd N.
  function automatic logic [W-1:0] half_div(input logic [W-1:0] n);
    return (n >> 1) + {{(W-1){1'b0}}, n[0]};
  endfunction

  assign cfg_ready = (state != PEND);
  assign running   = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign ratio_ok  = (cfg_div > ONE);
  assign boundary  = (cnt == cur_div - ONE);

  // Next-state, counter, ratio and phase decode for the controller.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = cur_div;
    pend_nxt  = pend_div;
    err_nxt   = accept && !ratio_ok;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept && ratio_ok) div_nxt = cfg_div;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = boundary ? '0 : cnt + ONE;
        if (boundary && !en) begin
          // Stopping at a boundary is already a safe point to load a new ratio.
          state_nxt = IDLE;
          if (accept && ratio_ok) div_nxt = cfg_div;
        end else if (accept && ratio_ok) begin
          pend_nxt  = cfg_div;
          state_nxt = PEND;
        end
      end
      PEND: begin
        cnt_nxt = boundary ? '0 : cnt + ONE;
        if (boundary) begin
          div_nxt   = pend_div;
          state_nxt = en ? RUN : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Phase a is decoded from the next counter value so the flop itself is
    // high exactly during the cycles where cnt < H of the ratio in effect.
    a_nxt = (state_nxt != IDLE) && (cnt_nxt < half_div(div_nxt));
  end

  // Controller state, counter, ratio registers and the posedge phase flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DEF_DIV;
      pend_div <= '0;
      a        <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= div_nxt;
      pend_div <= pend_nxt;
      a        <= a_nxt;
      cfg_err  <= err_nxt;
    end
  end

  // Negedge copy of a; ANDing with it trims half a cycle off odd high phases.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) b <= 1'b0;
    else       b <= a;
  end

  // Both a and b are low at every boundary, so switching the odd/even select
  // together with cur_div cannot glitch the output.
  assign clk_out = cur_div[0] ? (a & b) : a;

endmodule
